// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, block constants,
// initial hash values and the final-word marker insertion helper.
package sha256_pkg;

    typedef enum logic [2:0] {
        DATA   = 3'd0,
        MARK   = 3'd1,
        ZERO   = 3'd2,
        LEN_HI = 3'd3,
        LEN_LO = 3'd4
    } pad_state_t;

    localparam int          SHA256_BLK_WORDS = 16;
    localparam logic [31:0] SHA256_PAD_MARK  = 32'h80000000;

    localparam logic [0:7][31:0] SHA256_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Byte count of the final word; 5..7 behave as a full word.
    function automatic logic [2:0] clamp_nbytes(input logic [2:0] nbytes);
        return (nbytes > 3'd4) ? 3'd4 : nbytes;
    endfunction

    // Keep the first n bytes, put 0x80 at byte n, zero the rest.
    // With n = 4 the word passes through unchanged.
    function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                  input logic [2:0]  nbytes);
        logic [31:0] w;
        logic [2:0]  n;
        n = clamp_nbytes(nbytes);
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < n)
                w[31-8*i -: 8] = data[31-8*i -: 8];
            else if (3'(i) == n)
                w[31-8*i -: 8] = 8'h80;
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_pad_if.sv
// Input stream and padded output stream of the SHA-256 message padder.
interface sha256_pad_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        msg_done;
    logic        busy;

    modport master (
        output in_data, in_valid, in_last, in_nbytes, out_ready,
        input  in_ready, out_data, out_valid, msg_done, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, in_nbytes, out_ready,
        output in_ready, out_data, out_valid, msg_done, busy
    );
endinterface

// File: rtl/sha256_pad.sv
// SHA-256 message padder: passes message words straight through, then
// appends the 0x80 marker, zero fill and the 64-bit bit length so that
// the core only ever sees whole 16-word blocks.
//
//   state  | meaning
//   DATA   | message words pass through with zero latency
//   MARK   | emit 0x80000000 after a full final word
//   ZERO   | emit zero fill up to word index 13 (may span a block)
//   LEN_HI | emit bitlen[63:32] at word index 14
//   LEN_LO | emit bitlen[31:0] at word index 15, then back to DATA
module sha256_pad
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    sha256_pad_if.slave  pad
);

    localparam logic [3:0] LEN_IDX   = 4'(SHA256_BLK_WORDS - 2);
    localparam logic [3:0] ZERO_LAST = 4'(SHA256_BLK_WORDS - 3);

    pad_state_t  state;
    logic [3:0]  wcnt;
    logic [63:0] bitlen;

    logic [3:0]  wcnt_inc;
    logic [2:0]  n_eff;
    logic        out_valid_c;
    logic        out_xfer;
    logic [31:0] out_data_c;

    assign wcnt_inc    = wcnt + 4'd1;
    assign n_eff       = clamp_nbytes(pad.in_nbytes);
    assign out_valid_c = resetn & ((state == DATA) ? pad.in_valid : 1'b1);
    assign out_xfer    = out_valid_c & pad.out_ready;

    assign pad.out_valid = out_valid_c;
    assign pad.in_ready  = resetn & (state == DATA) & pad.out_ready;
    assign pad.msg_done  = out_xfer & (state == LEN_LO);
    assign pad.busy      = (state != DATA) || (wcnt != 4'd0);
    assign pad.out_data  = out_data_c;

    // Output word selection; padding words depend only on registers so they
    // stay stable under backpressure.
    always_comb begin
        out_data_c = '0;
        case (state)
            DATA:    out_data_c = pad.in_last ? pad_last_word(pad.in_data, pad.in_nbytes)
                                              : pad.in_data;
            MARK:    out_data_c = SHA256_PAD_MARK;
            ZERO:    out_data_c = '0;
            LEN_HI:  out_data_c = bitlen[63:32];
            LEN_LO:  out_data_c = bitlen[31:0];
            default: out_data_c = '0;
        endcase
    end

    // Sequencing, word index and running length advance only on output transfers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= DATA;
            wcnt   <= 4'd0;
            bitlen <= 64'd0;
        end else if (out_xfer) begin
            case (state)
                DATA: begin
                    wcnt <= wcnt_inc;
                    if (!pad.in_last) begin
                        bitlen <= bitlen + 64'd32;
                    end else begin
                        bitlen <= bitlen + {58'd0, n_eff, 3'b000};
                        if (n_eff == 3'd4)
                            state <= MARK;
                        else if (wcnt_inc == LEN_IDX)
                            state <= LEN_HI;
                        else
                            state <= ZERO;
                    end
                end
                MARK: begin
                    wcnt  <= wcnt_inc;
                    state <= (wcnt_inc == LEN_IDX) ? LEN_HI : ZERO;
                end
                ZERO: begin
                    wcnt <= wcnt_inc;
                    if (wcnt == ZERO_LAST)
                        state <= LEN_HI;
                end
                LEN_HI: begin
                    wcnt  <= wcnt_inc;
                    state <= LEN_LO;
                end
                LEN_LO: begin
                    wcnt   <= 4'd0;
                    bitlen <= 64'd0;
                    state  <= DATA;
                end
                default: state <= DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_pad.sv
// Self-checking bench for sha256_pad: messages are padded by a byte-level
// reference model and the DUT output stream is compared word by word.
module tb_sha256_pad;

    logic clk;
    logic resetn;

    sha256_pad_if pad_bus ();

    sha256_pad dut (
        .clk    (clk),
        .resetn (resetn),
        .pad    (pad_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  msg_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] in_w[$];
    logic        in_l[$];
    logic [2:0]  in_n[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference padding: append 0x80, zero bytes until 56 mod 64, then
    // the 64-bit big-endian bit length; regroup into words.
    task automatic build_expected();
        logic [7:0]  b[$];
        logic [63:0] blen;
        b = msg_q;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        blen = 64'(msg_q.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) b.push_back(blen[8*k +: 8]);
        exp_q.delete();
        for (int w = 0; w < b.size() / 4; w++)
            exp_q.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
    endtask

    // Split the message into input words; bytes past the end are junk.
    task automatic build_inputs(input bit nb7);
        int len, nin, rem;
        logic [31:0] w;
        len = msg_q.size();
        nin = (len == 0) ? 1 : (len + 3) / 4;
        in_w.delete(); in_l.delete(); in_n.delete();
        for (int i = 0; i < nin; i++) begin
            for (int k = 0; k < 4; k++)
                w[31-8*k -: 8] = (4*i + k < len) ? msg_q[4*i + k] : 8'($urandom_range(255));
            in_w.push_back(w);
            in_l.push_back(i == nin - 1);
            if (i == nin - 1) begin
                rem = len - 4*i;
                in_n.push_back((nb7 && rem == 4) ? 3'd7 : 3'(rem));
            end else begin
                in_n.push_back(3'($urandom_range(7)));
            end
        end
    endtask

    function automatic void rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(255)));
    endfunction

    // Drive one message and check every output cycle. Called just after a
    // rising edge; returns just after a rising edge. abort_at >= 0 stops
    // once that many output words have been taken.
    task automatic run_msg(input string tag, input bit rand_ready, input bit rand_gap,
                           input int abort_at, input bit nb7);
        int  widx, oidx, cycles, nin;
        bit  pend, stalled, xfer;
        logic [31:0] stall_data;
        build_expected();
        build_inputs(nb7);
        nin = in_w.size();
        widx = 0; oidx = 0; cycles = 0; pend = 0; stalled = 0; stall_data = '0;
        while (oidx < exp_q.size() && cycles < 4000 && !(abort_at >= 0 && oidx == abort_at)) begin
            if (!pend)
                pad_bus.in_valid = (widx < nin) && (!rand_gap || $urandom_range(3) != 0);
            if (widx < nin) begin
                pad_bus.in_data   = in_w[widx];
                pad_bus.in_last   = in_l[widx];
                pad_bus.in_nbytes = in_n[widx];
            end
            pad_bus.out_ready = !rand_ready || ($urandom_range(2) != 0);
            @(negedge clk);
            xfer = pad_bus.out_valid && pad_bus.out_ready;
            if (stalled) begin
                check({tag, " hold_valid"}, 64'(pad_bus.out_valid), 64'd1);
                check({tag, " hold_data"}, 64'(pad_bus.out_data), 64'(stall_data));
            end
            check({tag, " busy"}, 64'(pad_bus.busy), 64'((oidx % 16 != 0) || (oidx >= nin)));
            check({tag, " msg_done"}, 64'(pad_bus.msg_done), 64'(xfer && oidx == exp_q.size() - 1));
            if (xfer) begin
                check($sformatf("%s word%0d", tag, oidx), 64'(pad_bus.out_data), 64'(exp_q[oidx]));
                oidx++;
            end
            pend = pad_bus.in_valid && !pad_bus.in_ready;
            if (pad_bus.in_valid && pad_bus.in_ready) widx++;
            stalled = pad_bus.out_valid && !pad_bus.out_ready;
            stall_data = pad_bus.out_data;
            @(posedge clk); #1;
            cycles++;
        end
        pad_bus.in_valid = 1'b0;
        if (cycles >= 4000) check({tag, " timeout"}, 64'(oidx), 64'(exp_q.size()));
        if (abort_at < 0) begin
            check({tag, " nwords"}, 64'(oidx),
                  64'(16 * ((8 * msg_q.size() + 65 + 511) / 512)));
            check({tag, " inputs_taken"}, 64'(widx), 64'(nin));
            pad_bus.out_ready = 1'b1;
            @(negedge clk);
            check({tag, " idle_busy"}, 64'(pad_bus.busy), 64'd0);
            check({tag, " idle_valid"}, 64'(pad_bus.out_valid), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " out_valid"}, 64'(pad_bus.out_valid), 64'd0);
        check({tag, " in_ready"}, 64'(pad_bus.in_ready), 64'd0);
        check({tag, " busy"}, 64'(pad_bus.busy), 64'd0);
        check({tag, " msg_done"}, 64'(pad_bus.msg_done), 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        pad_bus.in_data   = '0;
        pad_bus.in_valid  = 1'b1;
        pad_bus.in_last   = 1'b0;
        pad_bus.in_nbytes = '0;
        pad_bus.out_ready = 1'b1;
        #2;
        check_reset_outputs("reset");
        pad_bus.in_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Empty message
        msg_q.delete();
        run_msg("empty", 0, 0, -1, 0);

        // "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", 0, 0, -1, 0);

        // 55 bytes: marker lands at the end of word 13, one block
        rand_msg(55);
        run_msg("len55", 0, 0, -1, 0);

        // 56 bytes: marker at word 14, length spills to a second block
        rand_msg(56);
        run_msg("len56", 0, 0, -1, 0);

        // 60 bytes: marker at word 15
        rand_msg(60);
        run_msg("len60", 1, 0, -1, 0);

        // 64 bytes: full block of data then marker at index 0 of the next
        rand_msg(64);
        run_msg("len64", 1, 1, -1, 0);

        // Illegal nbytes 7 on a full final word behaves as 4
        rand_msg(8);
        run_msg("nb7", 0, 0, -1, 1);

        // Backpressure and input gaps on random lengths
        for (int r = 0; r < 8; r++) begin
            rand_msg($urandom_range(130));
            run_msg($sformatf("rnd%0d", r), 1, 1, -1, 0);
        end

        // Reset in the middle of zero fill, then a clean "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abort", 0, 0, 5, 0);
        pad_bus.in_valid  = 1'b1;
        pad_bus.out_ready = 1'b1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pad_bus.in_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc_after_reset", 1, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
